// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag bundle.
// Build option ALU_BARREL_SHIFT_EN (used by alu_shifter/alu_seq) does not change these types.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SLTU = 4'b1000,
        OP_SLL  = 4'b1001,
        OP_SRL  = 4'b1010,
        OP_SRA  = 4'b1011,
        OP_NOR  = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
        logic illegal;
    } alu_flags_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic alu_flags_t mk_flags(input logic z, input logic n, input logic c,
                                            input logic v, input logic ill);
        alu_flags_t f;
        f.z       = z;
        f.n       = n;
        f.c       = c;
        f.v       = v;
        f.illegal = ill;
        return f;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift unit for alu_seq. ALU_BARREL_SHIFT_EN defined: single-cycle barrel shifter;
// undefined: iterative shifter, one bit per clock, with its own working register and counter.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [SHW-1:0]   i_shamt,
    output logic             o_imm_ok,
    output logic [WIDTH-1:0] o_imm_result,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_step_result
);

`ifdef ALU_BARREL_SHIFT_EN
    always_comb begin
        o_imm_result = i_a;
        case (i_op)
            OP_SLL:  o_imm_result = i_a << i_shamt;
            OP_SRL:  o_imm_result = i_a >> i_shamt;
            OP_SRA:  o_imm_result = $signed(i_a) >>> i_shamt;
            default: o_imm_result = i_a;
        endcase
    end

    assign o_imm_ok      = 1'b1;
    assign o_busy        = 1'b0;
    assign o_done        = 1'b0;
    assign o_step_result = '0;
`else
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_count;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] w_step;

    always_comb begin
        w_step = r_work;
        case (r_op)
            OP_SLL:  w_step = {r_work[WIDTH-2:0], 1'b0};
            OP_SRL:  w_step = {1'b0, r_work[WIDTH-1:1]};
            OP_SRA:  w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_step = r_work;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_count <= '0;
            r_op    <= '0;
        end else if (i_start) begin
            r_work  <= i_a;
            r_count <= i_shamt;
            r_op    <= i_op;
        end else if (o_busy) begin
            r_work  <= w_step;
            r_count <= r_count - SHW'(1);
        end
    end

    // o_done marks the edge that performs the last single-bit shift.
    assign o_busy        = (r_count != '0);
    assign o_done        = (r_count == SHW'(1));
    assign o_step_result = w_step;
    assign o_imm_ok      = (i_shamt == '0);
    assign o_imm_result  = i_a;
`endif

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute ALU: logic/add/sub/compare/shift with registered result and flags.
// Build option ALU_BARREL_SHIFT_EN makes shifts single-cycle; otherwise shifts take 1 + shamt cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zflag,
    output logic             out_nflag,
    output logic             out_cflag,
    output logic             out_vflag,
    output logic             out_illegal,
    output alu_state_e       o_dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e       r_state, w_state_next;
    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;

    logic             w_accept, w_is_shift, w_go_shift, w_cap_new, w_cap_shift;
    logic             w_sh_imm_ok, w_sh_busy, w_sh_done;
    logic [WIDTH-1:0] w_sh_imm, w_sh_step;
    logic             w_sub, w_ovf;
    logic [WIDTH-1:0] w_b_eff, w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_c, w_v, w_ill;
    alu_flags_t       w_flags, w_flags_shift;

    // SUB shares the adder: a + ~b + 1, so the carry-out is the no-borrow flag.
    assign w_sub   = (in_op == OP_SUB);
    assign w_b_eff = w_sub ? ~in_b : in_b;
    assign w_sum   = {1'b0, in_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};
    assign w_ovf   = (in_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_ill = 1'b0;
        case (in_op)
            OP_AND:  w_res = in_a & in_b;
            OP_OR:   w_res = in_a | in_b;
            OP_XOR:  w_res = in_a ^ in_b;
            OP_NOR:  w_res = ~(in_a | in_b);
            OP_ADD, OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_ovf;
            end
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_SLL, OP_SRL, OP_SRA: w_res = w_sh_imm;
            default: w_ill = 1'b1;
        endcase
    end

    assign w_flags       = mk_flags(w_res == '0, w_res[WIDTH-1], w_c, w_v, w_ill);
    assign w_flags_shift = mk_flags(w_sh_step == '0, w_sh_step[WIDTH-1], 1'b0, 1'b0, 1'b0);

    assign w_is_shift = is_shift_op(in_op);
    assign w_go_shift = w_is_shift && !w_sh_imm_ok;

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (w_accept && w_is_shift),
        .i_op          (in_op),
        .i_a           (in_a),
        .i_shamt       (in_b[SHW-1:0]),
        .o_imm_ok      (w_sh_imm_ok),
        .o_imm_result  (w_sh_imm),
        .o_busy        (w_sh_busy),
        .o_done        (w_sh_done),
        .o_step_result (w_sh_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_cap_new    = 1'b0;
        w_cap_shift  = 1'b0;
        in_ready     = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
        w_accept     = in_valid && in_ready;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_next = w_go_shift ? ST_SHIFT : ST_DONE;
                    w_cap_new    = !w_go_shift;
                end else if ((r_state == ST_DONE) && out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_sh_done) begin
                    w_state_next = ST_DONE;
                    w_cap_shift  = 1'b1;
                end else if (!w_sh_busy) begin
                    // Shifter idle without a finish pulse: recover rather than hang.
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_cap_new) begin
            r_result <= w_res;
            r_flags  <= w_flags;
        end else if (w_cap_shift) begin
            r_result <= w_sh_step;
            r_flags  <= w_flags_shift;
        end
    end

    assign out_valid   = (r_state == ST_DONE);
    assign out_result  = r_result;
    assign out_zflag   = r_flags.z;
    assign out_nflag   = r_flags.n;
    assign out_cflag   = r_flags.c;
    assign out_vflag   = r_flags.v;
    assign out_illegal = r_flags.illegal;
    assign o_dbg_state = r_state;

endmodule
